// File: rtl/accel_core_pkg.sv
`default_nettype none
// accel_core_pkg: shared datapath defaults and feeder FSM encoding for the accelerator core.
// Revision: 1.0
package accel_core_pkg;

    localparam int DEF_BIT_WIDTH   = 8;
    localparam int DEF_NUM_CHANNEL = 3;
    localparam int DEF_NUM_KERNEL  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/accel_feeder_bram.sv
`default_nettype none
// accel_feeder_bram: simple dual-port RAM, synchronous read-first, resettable/holding read register.
// Revision: 1.0
module accel_feeder_bram #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Kept outside the array process so the storage itself carries no reset;
    // the register holds its last value whenever no read is issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/accel_input_feeder.sv
`default_nettype none
// accel_input_feeder: streams data/weight words from local buffers to the core on request.
// Optional FEEDER_ERR_CNT_EN enables the ignored-request counter. Revision: 1.0
module accel_input_feeder
    import accel_core_pkg::*;
#(
    parameter int BIT_WIDTH    = DEF_BIT_WIDTH,
    parameter int NUM_CHANNEL  = DEF_NUM_CHANNEL,
    parameter int NUM_KERNEL   = DEF_NUM_KERNEL,
    parameter int DATA_DEPTH   = 256,
    parameter int WEIGHT_DEPTH = 64,
    parameter int REG_WIDTH    = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_start,
    input  logic [$clog2(DATA_DEPTH):0]               cfg_data_len,
    input  logic [$clog2(WEIGHT_DEPTH):0]             cfg_weight_len,
    input  logic                                      dbuf_wr_en,
    input  logic [$clog2(DATA_DEPTH)-1:0]             dbuf_wr_addr,
    input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          dbuf_wr_data,
    input  logic                                      wbuf_wr_en,
    input  logic [$clog2(WEIGHT_DEPTH)-1:0]           wbuf_wr_addr,
    input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] wbuf_wr_data,
    input  logic                                      o_data_req,
    output logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_data,
    output logic                                      i_data_val,
    input  logic                                      o_weight_req,
    output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_weight,
    output logic                                      i_weight_val,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [REG_WIDTH-1:0]                      o_err_cnt
);

    localparam int DAW = $clog2(DATA_DEPTH);
    localparam int WAW = $clog2(WEIGHT_DEPTH);
    localparam int DW  = BIT_WIDTH * NUM_CHANNEL;
    localparam int WW  = DW * NUM_KERNEL;

    feeder_state_t  state, state_nxt;
    logic [DAW:0]   data_len;
    logic [WAW-1:0] weight_last;
    logic [DAW-1:0] data_addr;
    logic [WAW-1:0] weight_addr;
    logic           launch;
    logic           data_acc;
    logic           weight_acc;
    logic           data_last_acc;

    always_comb begin
        launch        = (state == ST_IDLE) && i_start;
        data_acc      = (state == ST_RUN) && o_data_req && (data_len != '0);
        weight_acc    = ((state == ST_RUN) || (state == ST_DRAIN)) && o_weight_req;
        data_last_acc = data_acc && ({1'b0, data_addr} == (data_len - {{DAW{1'b0}}, 1'b1}));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_RUN;
            ST_RUN: begin
                if (data_len == '0) begin
                    state_nxt = ST_DONE;
                end else if (data_last_acc) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (i_data_val) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            data_len     <= '0;
            weight_last  <= '0;
            data_addr    <= '0;
            weight_addr  <= '0;
            i_data_val   <= 1'b0;
            i_weight_val <= 1'b0;
        end else begin
            state        <= state_nxt;
            i_data_val   <= data_acc;
            i_weight_val <= weight_acc;
            if (launch) begin
                data_len    <= cfg_data_len;
                // A length of 0 (or the full depth) wraps over the whole buffer.
                weight_last <= ((cfg_weight_len == '0) || cfg_weight_len[WAW]) ?
                               {WAW{1'b1}} : (cfg_weight_len[WAW-1:0] - {{(WAW-1){1'b0}}, 1'b1});
                data_addr   <= '0;
                weight_addr <= '0;
            end else begin
                if (data_acc) begin
                    data_addr <= data_addr + {{(DAW-1){1'b0}}, 1'b1};
                end
                if (weight_acc) begin
                    weight_addr <= (weight_addr == weight_last) ? '0 :
                                   weight_addr + {{(WAW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign o_busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign o_done = (state == ST_DONE);

    accel_feeder_bram #(
        .WIDTH (DW),
        .DEPTH (DATA_DEPTH)
    ) u_dbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (dbuf_wr_en),
        .wr_addr (dbuf_wr_addr),
        .wr_data (dbuf_wr_data),
        .rd_en   (data_acc),
        .rd_addr (data_addr),
        .rd_data (i_data)
    );

    accel_feeder_bram #(
        .WIDTH (WW),
        .DEPTH (WEIGHT_DEPTH)
    ) u_wbuf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wbuf_wr_en),
        .wr_addr (wbuf_wr_addr),
        .wr_data (wbuf_wr_data),
        .rd_en   (weight_acc),
        .rd_addr (weight_addr),
        .rd_data (i_weight)
    );

`ifdef FEEDER_ERR_CNT_EN
    logic [1:0]         ign_cnt;
    logic [REG_WIDTH:0] err_sum;

    always_comb begin
        ign_cnt = {1'b0, o_data_req && !data_acc} + {1'b0, o_weight_req && !weight_acc};
        err_sum = {1'b0, o_err_cnt} + {{(REG_WIDTH-1){1'b0}}, ign_cnt};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_err_cnt <= '0;
        end else if (err_sum[REG_WIDTH]) begin
            o_err_cnt <= '1;
        end else begin
            o_err_cnt <= err_sum[REG_WIDTH-1:0];
        end
    end
`else
    assign o_err_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_accel_input_feeder.sv
`default_nettype none
// tb_accel_input_feeder: randomized self-checking bench against a transaction-level feeder model.
// Revision: 1.0
module tb_accel_input_feeder;

    localparam int DD = 256;
    localparam int WD = 64;
    localparam int DW = 24;
    localparam int WW = 96;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_start = 1'b0;
    logic [8:0]    cfg_data_len = '0;
    logic [6:0]    cfg_weight_len = '0;
    logic          dbuf_wr_en = 1'b0;
    logic [7:0]    dbuf_wr_addr = '0;
    logic [DW-1:0] dbuf_wr_data = '0;
    logic          wbuf_wr_en = 1'b0;
    logic [5:0]    wbuf_wr_addr = '0;
    logic [WW-1:0] wbuf_wr_data = '0;
    logic          o_data_req = 1'b0;
    logic          o_weight_req = 1'b0;
    logic [DW-1:0] i_data;
    logic          i_data_val;
    logic [WW-1:0] i_weight;
    logic          i_weight_val;
    logic          o_busy;
    logic          o_done;
    logic [31:0]   o_err_cnt;

    accel_input_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .cfg_data_len   (cfg_data_len),
        .cfg_weight_len (cfg_weight_len),
        .dbuf_wr_en     (dbuf_wr_en),
        .dbuf_wr_addr   (dbuf_wr_addr),
        .dbuf_wr_data   (dbuf_wr_data),
        .wbuf_wr_en     (wbuf_wr_en),
        .wbuf_wr_addr   (wbuf_wr_addr),
        .wbuf_wr_data   (wbuf_wr_data),
        .o_data_req     (o_data_req),
        .i_data         (i_data),
        .i_data_val     (i_data_val),
        .o_weight_req   (o_weight_req),
        .i_weight       (i_weight),
        .i_weight_val   (i_weight_val),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err_cnt      (o_err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: buffer images plus run progress counted in words.
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic [DW-1:0] dmem [DD];
    logic [WW-1:0] wmem [WD];
    int            m_mode;
    int            m_dlen;
    int            m_wlen;
    int            m_didx;
    int            m_widx;
    logic [DW-1:0] m_data;
    logic [WW-1:0] m_weight;
    logic          m_dval;
    logic          m_wval;
    longint        m_err;
    int            n_cmp;
    int            n_bad;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic quiet();
        i_start      = 1'b0;
        o_data_req   = 1'b0;
        o_weight_req = 1'b0;
        dbuf_wr_en   = 1'b0;
        wbuf_wr_en   = 1'b0;
    endtask

    task automatic serve_weight();
        m_weight = wmem[m_widx];
        m_wval   = 1'b1;
        m_widx   = (m_widx + 1) % m_wlen;
    endtask

    // Predict the effect of the current inputs, clock once, compare all outputs.
    task automatic tick();
        int ign;
        int nmode;
        ign    = 0;
        nmode  = m_mode;
        m_dval = 1'b0;
        m_wval = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (i_start) begin
                    m_dlen = int'(cfg_data_len);
                    m_wlen = (cfg_weight_len == 0) ? WD : int'(cfg_weight_len);
                    m_didx = 0;
                    m_widx = 0;
                    nmode  = M_RUN;
                end
                ign = int'(o_data_req) + int'(o_weight_req);
            end
            M_RUN: begin
                if (m_dlen == 0) begin
                    nmode = M_DONE;
                    ign  += int'(o_data_req);
                end else if (o_data_req) begin
                    m_data = dmem[m_didx];
                    m_dval = 1'b1;
                    m_didx++;
                    if (m_didx == m_dlen) nmode = M_DRAIN;
                end
                if (o_weight_req) serve_weight();
            end
            M_DRAIN: begin
                nmode = M_DONE;
                ign  += int'(o_data_req);
                if (o_weight_req) serve_weight();
            end
            default: begin
                nmode = M_IDLE;
                ign   = int'(o_data_req) + int'(o_weight_req);
            end
        endcase
        if (dbuf_wr_en) dmem[dbuf_wr_addr] = dbuf_wr_data;
        if (wbuf_wr_en) wmem[wbuf_wr_addr] = wbuf_wr_data;
        m_err  = (m_err + ign > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_err + ign;
        m_mode = nmode;

        @(posedge clk);
        #1;
        chk("data_val", i_data_val, m_dval);
        chk("data", i_data, m_data);
        chk("weight_val", i_weight_val, m_wval);
        chk("weight", i_weight, m_weight);
        chk("busy", o_busy, (m_mode == M_RUN) || (m_mode == M_DRAIN));
        chk("done", o_done, m_mode == M_DONE);
`ifdef FEEDER_ERR_CNT_EN
        chk("err_cnt", o_err_cnt, m_err[31:0]);
`else
        chk("err_cnt", o_err_cnt, 32'd0);
`endif
    endtask

    task automatic async_reset();
        quiet();
        rst = 1'b0;
        #2;
        chk("rst_data", i_data, 0);
        chk("rst_data_val", i_data_val, 0);
        chk("rst_weight", i_weight, 0);
        chk("rst_weight_val", i_weight_val, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err_cnt, 0);
        m_mode   = M_IDLE;
        m_data   = '0;
        m_weight = '0;
        m_err    = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic start_run(input int dlen, input int wlen);
        quiet();
        cfg_data_len   = 9'(dlen);
        cfg_weight_len = 7'(wlen);
        i_start        = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic finish_run();
        int guard;
        quiet();
        guard = 0;
        while (m_mode != M_IDLE && guard < 100) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_mode = M_IDLE;
        m_dlen = 0;
        m_wlen = WD;
        m_didx = 0;
        m_widx = 0;
        m_err  = 0;
        m_data = '0;
        m_weight = '0;
        #1;
        async_reset();

        // Fill both buffers; weight word carries its address in the top 32 bits.
        for (int i = 0; i < DD; i++) begin
            dbuf_wr_en   = 1'b1;
            dbuf_wr_addr = 8'(i);
            dbuf_wr_data = (i < 8) ? 24'(i * 24'h010101) : 24'($urandom);
            wbuf_wr_en   = (i < WD);
            wbuf_wr_addr = 6'(i % WD);
            wbuf_wr_data = {32'(i), 32'($urandom), 32'($urandom)};
            tick();
        end
        quiet();

        // Eight back-to-back data requests with weight requests alongside.
        start_run(8, 3);
        for (int k = 0; k < 8; k++) begin
            o_data_req   = 1'b1;
            o_weight_req = 1'b1;
            tick();
            chk("seq_data", i_data, 24'(k * 24'h010101));
            chk("seq_waddr", i_weight[95:64], 32'(k % 3));
            chk("seq_both_val", {i_data_val, i_weight_val}, 2'b11);
        end
        quiet();
        tick();
        chk("seq_done", o_done, 1'b1);
        finish_run();

        // Weight address wrap with length 3.
        start_run(2, 3);
        for (int k = 0; k < 7; k++) begin
            o_weight_req = 1'b1;
            tick();
            chk("wrap_waddr", i_weight[95:64], 32'(k % 3));
        end
        quiet();
        o_data_req = 1'b1;
        tick();
        tick();
        finish_run();

        // Requests while idle are dropped.
        for (int k = 0; k < 3; k++) begin
            o_data_req = 1'b1;
            tick();
        end
        quiet();
`ifdef FEEDER_ERR_CNT_EN
        chk("idle_err", o_err_cnt, 32'd3);
`else
        chk("idle_err", o_err_cnt, 32'd0);
`endif

        // Reset in the middle of a run, then restart from address 0.
        start_run(8, 0);
        for (int k = 0; k < 4; k++) begin
            o_data_req = 1'b1;
            tick();
        end
        async_reset();
        dbuf_wr_en   = 1'b1;
        dbuf_wr_addr = 8'd0;
        dbuf_wr_data = 24'hABCDEF;
        tick();
        chk("rst_no_done", o_done, 1'b0);
        start_run(8, 0);
        o_data_req = 1'b1;
        tick();
        chk("restart_data", i_data, 24'hABCDEF);
        for (int k = 1; k < 8; k++) tick();
        finish_run();

        // Empty run.
        start_run(0, 4);
        chk("empty_busy", o_busy, 1'b1);
        tick();
        chk("empty_done", o_done, 1'b1);
        chk("empty_busy2", o_busy, 1'b0);
        finish_run();

        // Randomized runs with concurrent buffer writes and stray starts.
        for (int r = 0; r < 25; r++) begin
            int guard;
            start_run($urandom_range(1, 24), $urandom_range(0, 6));
            guard = 0;
            while (m_mode != M_IDLE && guard < 500) begin
                o_data_req     = ($urandom_range(0, 3) != 0);
                o_weight_req   = $urandom_range(0, 1) != 0;
                i_start        = ($urandom_range(0, 15) == 0);
                cfg_data_len   = 9'($urandom_range(0, 30));
                cfg_weight_len = 7'($urandom_range(0, 8));
                dbuf_wr_en     = ($urandom_range(0, 3) == 0);
                dbuf_wr_addr   = 8'($urandom_range(0, 31));
                dbuf_wr_data   = 24'($urandom);
                wbuf_wr_en     = ($urandom_range(0, 3) == 0);
                wbuf_wr_addr   = 6'($urandom_range(0, 7));
                wbuf_wr_data   = {32'($urandom), 32'($urandom), 32'($urandom)};
                tick();
                guard++;
            end
            quiet();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                o_data_req   = $urandom_range(0, 1) != 0;
                o_weight_req = $urandom_range(0, 1) != 0;
                tick();
            end
            quiet();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/accel_input_feeder.md
ACCEL_INPUT_FEEDER -- requirements
Module: accel_input_feeder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, meaning bits per channel element.
REQ-002 SHALL have parameter NUM_CHANNEL, default 3, meaning channels per data word.
REQ-003 SHALL have parameter NUM_KERNEL, default 4, meaning kernels per weight word.
REQ-004 SHALL have parameter DATA_DEPTH, default 256, meaning data buffer entries (power of 2).
REQ-005 SHALL have parameter WEIGHT_DEPTH, default 64, meaning weight buffer entries (power of 2).
REQ-006 SHALL have parameter REG_WIDTH, default 32, meaning status counter width.
REQ-007 SHALL have ports: clk input 1 system clock; rst input 1 reset, one clock, asynchronous, active-low.
REQ-008 SHALL have ports: i_start input 1 run start pulse; cfg_data_len input log2(DATA_DEPTH)+1 data words per run; cfg_weight_len input log2(WEIGHT_DEPTH)+1 weight words per wrap period.
REQ-009 SHALL have ports: dbuf_wr_en input 1; dbuf_wr_addr input log2(DATA_DEPTH); dbuf_wr_data input BIT_WIDTH*NUM_CHANNEL -- data buffer load.
REQ-010 SHALL have ports: wbuf_wr_en input 1; wbuf_wr_addr input log2(WEIGHT_DEPTH); wbuf_wr_data input BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL -- weight buffer load.
REQ-011 SHALL have ports: o_data_req input 1 core data request; i_data output BIT_WIDTH*NUM_CHANNEL; i_data_val output 1.
REQ-012 SHALL have ports: o_weight_req input 1 core weight request; i_weight output BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL; i_weight_val output 1.
REQ-013 SHALL have ports: o_busy output 1 run active; o_done output 1 run-complete pulse; o_err_cnt output REG_WIDTH ignored-request count.

Function
REQ-014 SHALL implement FSM IDLE -> RUN (i_start in IDLE) -> DRAIN (last data request accepted) -> DONE (one cycle) -> IDLE.
REQ-015 SHALL latch cfg_data_len and cfg_weight_len on i_start in IDLE and clear both read addresses to 0.
REQ-016 SHALL ignore i_start outside IDLE.
REQ-017 SHALL, in RUN, accept o_data_req each cycle asserted, read data buffer at data address, and present i_data with i_data_val high exactly one cycle later, for one cycle.
REQ-018 SHALL increment data address per accepted request; acceptance at address cfg_data_len-1 moves FSM to DRAIN.
REQ-019 SHALL, in RUN and DRAIN, accept o_weight_req with same 1-cycle latency and one-cycle i_weight_val pulse, weight address wrapping from cfg_weight_len-1 to 0.
REQ-020 SHALL serve simultaneous data and weight requests independently in the same cycle.
REQ-021 SHALL leave DRAIN after the final i_data_val pulse; o_done high only in DONE; o_busy high in RUN and DRAIN.
REQ-022 SHALL treat cfg_data_len 0 as an empty run: RUN -> DONE next cycle, no data pulses.
REQ-023 SHALL treat cfg_weight_len 0 as WEIGHT_DEPTH.
REQ-024 SHALL ignore o_data_req outside RUN and o_weight_req outside RUN/DRAIN (no valid pulse).
REQ-025 SHALL hold i_data / i_weight at last read value when valid low.
REQ-026 SHALL accept buffer writes in any state; same-cycle read and write to one address returns old contents (read-first).

Reset
REQ-027 SHALL, on rst low, asynchronously force FSM IDLE, addresses 0, i_data 0, i_weight 0, both valids 0, o_busy 0, o_done 0, o_err_cnt 0; buffer contents not reset.
REQ-028 SHALL, on reset mid-run, abandon the run without o_done.

Configuration
REQ-029 SHALL, with FEEDER_ERR_CNT_EN defined, increment o_err_cnt per ignored request (data and weight same cycle count 2), saturating at all-ones.
REQ-030 SHALL, without FEEDER_ERR_CNT_EN, tie o_err_cnt to 0 and omit counter logic.

Structure
REQ-031 SHALL take BIT_WIDTH, NUM_CHANNEL, NUM_KERNEL defaults and FSM state encodings from shared package accel_core_pkg.
REQ-032 SHALL instantiate sub-module accel_feeder_bram (simple dual-port, sync read-first) twice, for data and weight buffers.

Verification
REQ-033 SHALL cover: load data 0..7 = 24'h000000+k*24'h010101, len 8, start, 8 back-to-back requests -> i_data 0x000000..0x070707 each one cycle after request, o_done one cycle after last valid.
REQ-034 SHALL cover: weight len 3, 7 weight requests -> weight addresses 0,1,2,0,1,2,0.
REQ-035 SHALL cover: data and weight requests every cycle simultaneously -> both valids pulse together each cycle, counts equal.
REQ-036 SHALL cover: 3 data requests in IDLE with FEEDER_ERR_CNT_EN -> no i_data_val, o_err_cnt = 3; without macro o_err_cnt = 0.
REQ-037 SHALL cover: rst low after 4 of 8 requests -> all outputs 0 immediately, no o_done; restart returns address 0 data.
REQ-038 SHALL cover: cfg_data_len 0 start -> o_busy one cycle, o_done next, zero data valids.
